// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch FIFO owning the fetch PC, with redirect, stall and interrupt entry
module fetch_queue #(
    parameter int          DATA_W     = 32,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_inst,
    output logic [DATA_W-1:0] id_pc,
    input  logic              id_ready,
    input  logic              redirect,
    input  logic [DATA_W-1:0] redirect_pc,
    input  logic              irq,
    output logic              irq_ack,
    output logic [DATA_W-1:0] epc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_fpc;
    logic [DATA_W-1:0] r_epc;
    logic              r_irq_ack;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [DATA_W-1:0] r_mem_pc   [DEPTH];
    logic [DATA_W-1:0] r_mem_inst [DEPTH];

    logic [DATA_W-1:0] w_ret_pc;
    logic [DATA_W-1:0] w_pc_inc;
    logic              w_irq_take;
    logic              w_flush;
    logic              w_pop;
    logic              w_push;

    assign imem_addr = r_fpc;
    assign id_valid  = (r_count != '0);
    assign id_pc     = r_mem_pc[r_rd_ptr];
    assign id_inst   = r_mem_inst[r_rd_ptr];
    assign irq_ack   = r_irq_ack;
    assign epc       = r_epc;

    // Per-cycle decisions: redirect beats interrupt beats normal push/pop
    always_comb begin
        w_ret_pc   = id_valid ? id_pc : r_fpc;
        // The kernel flag in the top bit is preserved; the carry stops below it
        w_pc_inc   = {r_fpc[DATA_W-1], r_fpc[DATA_W-2:0] + (DATA_W-1)'(4)};
        w_irq_take = irq && !redirect && !w_ret_pc[DATA_W-1];
        w_flush    = redirect || w_irq_take;
        w_pop      = id_valid && id_ready && !w_flush;
        w_push     = !w_flush && ((r_count != FULL) || w_pop);
    end

    // Fetch PC, queue bookkeeping and interrupt state
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fpc     <= RESET_PC[DATA_W-1:0];
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_irq_ack <= 1'b0;
            r_epc     <= '0;
        end else begin
            r_irq_ack <= w_irq_take;
            if (redirect) begin
                r_fpc    <= redirect_pc;
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else if (w_irq_take) begin
                r_fpc    <= IRQ_VECTOR[DATA_W-1:0];
                r_epc    <= w_ret_pc;
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    r_fpc    <= w_pc_inc;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Entry storage; contents are only meaningful below the count, so no reset
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_fpc;
            r_mem_inst[r_wr_ptr] <= imem_data;
        end
    end

endmodule
